half_subtractor_unit: RTL and testbench
=======================================

// Module: half_subtractor_unit
// PURPOSE
//   Bitwise half subtractor: diff = a ^ b, borrow = ~a & b, over WIDTH independent lanes.
//   Combinational outputs feed local datapath logic directly.
//   Registered copies with a valid flag and a saturating borrow counter feed pipelined consumers and status logic.
//   Leaf arithmetic block used inside subtractor/comparator datapaths; WIDTH=1 is the classic 1-bit half subtractor.
// PARAMETERS
//   WIDTH      1   number of independent 1-bit half-subtractor lanes (>=1)
//   CNT_WIDTH  8   width of saturating borrow-event counter
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          synchronous reset, active-high
//   a           in   WIDTH      minuend bits
//   b           in   WIDTH      subtrahend bits
//   in_valid    in   1          a/b qualify for the registered path this cycle
//   diff        out  WIDTH      combinational difference, a ^ b
//   borrow      out  WIDTH      combinational borrow, ~a & b
//   diff_q      out  WIDTH      registered diff
//   borrow_q    out  WIDTH      registered borrow
//   out_valid   out  1          diff_q/borrow_q hold a valid result
//   borrow_cnt  out  CNT_WIDTH  count of valid cycles with any borrow lane set, saturating
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Combinational path (per lane i, no clock or reset dependence, zero latency):
//     a=0 b=0 -> diff=0 borrow=0
//     a=0 b=1 -> diff=1 borrow=1
//     a=1 b=0 -> diff=1 borrow=0
//     a=1 b=1 -> diff=0 borrow=0
//     Lanes never interact; there is no borrow-in or borrow chaining.
//     X/Z on a or b propagates; no masking.
//   Registered path, on posedge clk:
//     rst=1: diff_q=0, borrow_q=0, out_valid=0, borrow_cnt=0.
//       Reset has priority over in_valid and takes effect mid-stream on the next edge.
//     in_valid=1: diff_q<=diff, borrow_q<=borrow, out_valid<=1.
//       If |borrow, borrow_cnt<=borrow_cnt+1, saturating at all-ones (no wrap).
//     in_valid=0: out_valid<=0; diff_q, borrow_q and borrow_cnt hold.
//   Latency: 1 cycle from in_valid to out_valid. Throughput: 1 result per cycle.
//     No backpressure.
//   borrow_cnt counts at most 1 per cycle, regardless of how many lanes borrow.
//   Outputs are driven only by reset or the rules above. No other state.
// TESTING
//   Exhaustive, WIDTH=1: sweep (a,b)=00,01,10,11 with 10 time units per step.
//     -> diff/borrow = 0/0, 1/1, 1/0, 0/0.
//   Registered path: in_valid=1 with a=0, b=1.
//     -> next edge gives diff_q=1, borrow_q=1, out_valid=1, borrow_cnt=1.
//     in_valid=0 on the next cycle -> out_valid=0; diff_q, borrow_q and borrow_cnt hold.
//   Reset mid-stream: assert rst with in_valid=1.
//     -> next edge gives all registered outputs 0.
//     Combinational diff/borrow still track a/b.
//   Saturation, CNT_WIDTH=2: 5 valid cycles with a=0, b=1.
//     -> borrow_cnt = 1, 2, 3, 3, 3.
//   Multi-lane, WIDTH=4: a=4'b0011, b=4'b0101.
//     -> diff=4'b0110, borrow=4'b0100; borrow_cnt increments by exactly 1.

Source files
------------

// File: rtl/half_subtractor_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : half_subtractor_unit                                         |
// | Description : WIDTH-lane bitwise half subtractor with a registered copy,   |
// |               a valid flag and a saturating borrow-event counter.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module half_subtractor_unit #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     diff,
  output logic [WIDTH-1:0]     borrow,
  output logic [WIDTH-1:0]     diff_q,
  output logic [WIDTH-1:0]     borrow_q,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] borrow_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_borrow;
  logic                 w_any_borrow;
  logic [WIDTH-1:0]     r_diff_q;
  logic [WIDTH-1:0]     r_borrow_q;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_borrow_cnt;

  // Lanes are fully independent; no borrow-in or chaining between bits.
  assign w_diff       = a ^ b;
  assign w_borrow     = ~a & b;
  assign w_any_borrow = |w_borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff_q     <= '0;
      r_borrow_q   <= '0;
      r_out_valid  <= 1'b0;
      r_borrow_cnt <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_diff_q   <= w_diff;
        r_borrow_q <= w_borrow;
        // One count per borrowing cycle, held at all-ones rather than wrapping.
        if (w_any_borrow && (r_borrow_cnt != c_cnt_max)) begin
          r_borrow_cnt <= r_borrow_cnt + 1'b1;
        end
      end
    end
  end

  assign diff       = w_diff;
  assign borrow     = w_borrow;
  assign diff_q     = r_diff_q;
  assign borrow_q   = r_borrow_q;
  assign out_valid  = r_out_valid;
  assign borrow_cnt = r_borrow_cnt;

endmodule

`default_nettype wire

// File: tb/tb_half_subtractor_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_half_subtractor_unit                                      |
// | Description : Directed self-checking bench for half_subtractor_unit.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_half_subtractor_unit;

  logic clk;
  logic rst;

  // WIDTH=1, CNT_WIDTH=8
  logic       a1, b1, v1;
  logic       diff1, borrow1, diffq1, borrowq1, ov1;
  logic [7:0] cnt1;

  // WIDTH=1, CNT_WIDTH=2 (saturation)
  logic       as, bs, vs;
  logic       diffs, borrows, diffqs, borrowqs, ovs;
  logic [1:0] cnts;

  // WIDTH=4, CNT_WIDTH=8
  logic [3:0] a4, b4, diff4, borrow4, diffq4, borrowq4;
  logic       v4, ov4;
  logic [7:0] cnt4;

  int checks = 0;
  int errors = 0;

  half_subtractor_unit #(.WIDTH(1), .CNT_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .diff(diff1), .borrow(borrow1), .diff_q(diffq1), .borrow_q(borrowq1),
    .out_valid(ov1), .borrow_cnt(cnt1)
  );

  half_subtractor_unit #(.WIDTH(1), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst(rst), .a(as), .b(bs), .in_valid(vs),
    .diff(diffs), .borrow(borrows), .diff_q(diffqs), .borrow_q(borrowqs),
    .out_valid(ovs), .borrow_cnt(cnts)
  );

  half_subtractor_unit #(.WIDTH(4), .CNT_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .diff(diff4), .borrow(borrow4), .diff_q(diffq4), .borrow_q(borrowq4),
    .out_valid(ov4), .borrow_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    as = 1'b0; bs = 1'b0; vs = 1'b0;
    a4 = 4'h0; b4 = 4'h0; v4 = 1'b0;
    step();
    step();

    // Reset state of every instance
    chk("rst_diffq1",   32'(diffq1),   32'h0);
    chk("rst_borrowq1", 32'(borrowq1), 32'h0);
    chk("rst_ov1",      32'(ov1),      32'h0);
    chk("rst_cnt1",     32'(cnt1),     32'h0);
    chk("rst_cnts",     32'(cnts),     32'h0);
    chk("rst_ov4",      32'(ov4),      32'h0);
    chk("rst_cnt4",     32'(cnt4),     32'h0);
    rst = 1'b0;

    // Combinational truth table, 10 time units per vector
    a1 = 1'b0; b1 = 1'b0; #10;
    chk("tt00_diff", 32'(diff1), 32'h0); chk("tt00_borrow", 32'(borrow1), 32'h0);
    a1 = 1'b0; b1 = 1'b1; #10;
    chk("tt01_diff", 32'(diff1), 32'h1); chk("tt01_borrow", 32'(borrow1), 32'h1);
    a1 = 1'b1; b1 = 1'b0; #10;
    chk("tt10_diff", 32'(diff1), 32'h1); chk("tt10_borrow", 32'(borrow1), 32'h0);
    a1 = 1'b1; b1 = 1'b1; #10;
    chk("tt11_diff", 32'(diff1), 32'h0); chk("tt11_borrow", 32'(borrow1), 32'h0);
    // in_valid low throughout the sweep: nothing captured
    chk("sweep_ov1",  32'(ov1),  32'h0);
    chk("sweep_cnt1", 32'(cnt1), 32'h0);

    // Registered capture with borrow
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    step();
    chk("reg_diffq",   32'(diffq1),   32'h1);
    chk("reg_borrowq", 32'(borrowq1), 32'h1);
    chk("reg_ov",      32'(ov1),      32'h1);
    chk("reg_cnt",     32'(cnt1),     32'h1);

    // in_valid low: registers hold, out_valid drops
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
    step();
    chk("hold_diffq",   32'(diffq1),   32'h1);
    chk("hold_borrowq", 32'(borrowq1), 32'h1);
    chk("hold_ov",      32'(ov1),      32'h0);
    chk("hold_cnt",     32'(cnt1),     32'h1);

    // Valid result without a borrow: counter unchanged
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    step();
    chk("nob_diffq",   32'(diffq1),   32'h1);
    chk("nob_borrowq", 32'(borrowq1), 32'h0);
    chk("nob_ov",      32'(ov1),      32'h1);
    chk("nob_cnt",     32'(cnt1),     32'h1);

    // Reset mid-stream beats in_valid
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1; rst = 1'b1;
    step();
    chk("mrst_diffq",   32'(diffq1),   32'h0);
    chk("mrst_borrowq", 32'(borrowq1), 32'h0);
    chk("mrst_ov",      32'(ov1),      32'h0);
    chk("mrst_cnt",     32'(cnt1),     32'h0);
    chk("mrst_diff",    32'(diff1),    32'h1);
    chk("mrst_borrow",  32'(borrow1),  32'h1);
    rst = 1'b0; v1 = 1'b0;

    // Saturation with CNT_WIDTH=2
    as = 1'b0; bs = 1'b1; vs = 1'b1;
    step(); chk("sat_c1", 32'(cnts), 32'h1);
    step(); chk("sat_c2", 32'(cnts), 32'h2);
    step(); chk("sat_c3", 32'(cnts), 32'h3);
    step(); chk("sat_c4", 32'(cnts), 32'h3);
    step(); chk("sat_c5", 32'(cnts), 32'h3);
    chk("sat_ov", 32'(ovs), 32'h1);
    vs = 1'b0;

    // Multi-lane, WIDTH=4
    a4 = 4'b0011; b4 = 4'b0101; v4 = 1'b1;
    #1;
    chk("ml_diff",   32'(diff4),   32'h6);
    chk("ml_borrow", 32'(borrow4), 32'h4);
    step();
    chk("ml_diffq",   32'(diffq4),   32'h6);
    chk("ml_borrowq", 32'(borrowq4), 32'h4);
    chk("ml_cnt1",    32'(cnt4),     32'h1);
    a4 = 4'b1111; b4 = 4'b0000;
    step();
    chk("ml_nob_diffq", 32'(diffq4), 32'hF);
    chk("ml_cnt_nob",   32'(cnt4),   32'h1);
    // Four lanes borrowing at once still add only one
    a4 = 4'b0000; b4 = 4'b1111;
    step();
    chk("ml_borrowq_all", 32'(borrowq4), 32'hF);
    chk("ml_cnt2",        32'(cnt4),     32'h2);
    v4 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
